// File: rtl/axi4_lite_register_bank.sv
// AXI4-Lite slave register bank: 2**CLOG2_W registers of N bytes with byte strobes,
// read-only / write-one-to-clear registers, decode errors and per-register access pulses.
module axi4_lite_register_bank #(
    parameter int A       = 16,
    parameter int N       = 4,
    parameter int CLOG2_W = 4,
    parameter logic [(1 << CLOG2_W)-1:0] RO_MASK  = '0,
    parameter logic [(1 << CLOG2_W)-1:0] W1C_MASK = '0,
    parameter logic [N*8-1:0]            RST_VAL  = '0
) (
    input  logic                                   aclk,
    input  logic                                   areset,
    input  logic [A-1:0]                           awaddr,
    input  logic                                   awvalid,
    output logic                                   awready,
    input  logic [N*8-1:0]                         wdata,
    input  logic [N-1:0]                           wstrb,
    input  logic                                   wvalid,
    output logic                                   wready,
    output logic [1:0]                             bresp,
    output logic                                   bvalid,
    input  logic                                   bready,
    input  logic [A-1:0]                           araddr,
    input  logic                                   arvalid,
    output logic                                   arready,
    output logic [N*8-1:0]                         rdata,
    output logic [1:0]                             rresp,
    output logic                                   rvalid,
    input  logic                                   rready,
    output logic [(1 << CLOG2_W)-1:0][N*8-1:0]     register_out,
    input  logic [(1 << CLOG2_W)-1:0][N*8-1:0]     register_in,
    output logic [(1 << CLOG2_W)-1:0]              wr_pulse,
    output logic [(1 << CLOG2_W)-1:0]              rd_pulse
);

    localparam int W    = 1 << CLOG2_W;
    localparam int D    = N * 8;
    localparam int OFFS = $clog2(N);
    localparam int HI   = CLOG2_W + OFFS;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Handshake rule on every channel: a beat transfers on a rising edge where valid
    // and ready are both high; valid is never withdrawn by this slave before its beat.
    typedef enum logic {W_IDLE, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_RESP} r_state_t;

    function automatic logic [CLOG2_W-1:0] addr_index(input logic [A-1:0] addr);
        return addr[HI-1:OFFS];
    endfunction

    function automatic logic addr_oob(input logic [A-1:0] addr);
        return (addr >> HI) != '0;
    endfunction

    function automatic logic [D-1:0] merge_bytes(input logic [D-1:0] old,
                                                 input logic [D-1:0] data,
                                                 input logic [N-1:0] strb,
                                                 input logic         w1c);
        logic [D-1:0] res;
        res = old;
        for (int b = 0; b < N; b++) begin
            if (strb[b]) begin
                res[b*8 +: 8] = w1c ? (old[b*8 +: 8] & ~data[b*8 +: 8]) : data[b*8 +: 8];
            end
        end
        return res;
    endfunction

    // Low address bits are don't-care by design.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{awaddr, araddr};

    w_state_t         w_state, w_state_next;
    logic             aw_held, w_held;
    logic [A-1:0]     awaddr_q;
    logic [D-1:0]     wdata_q;
    logic [N-1:0]     wstrb_q;
    logic             aw_beat, w_beat, aw_have, w_have, commit, wr_ok;
    logic [A-1:0]     wr_addr;
    logic [D-1:0]     wr_data;
    logic [N-1:0]     wr_strb;
    logic [CLOG2_W-1:0] wr_idx;

    always_comb begin
        w_state_next = w_state;
        awready      = (w_state == W_IDLE) && !aw_held;
        wready       = (w_state == W_IDLE) && !w_held;
        bvalid       = (w_state == W_RESP);
        aw_beat      = awvalid && awready;
        w_beat       = wvalid && wready;
        aw_have      = aw_held || aw_beat;
        w_have       = w_held || w_beat;
        commit       = (w_state == W_IDLE) && aw_have && w_have;
        // A beat arriving this cycle is used directly so commit needs no extra cycle.
        wr_addr      = aw_held ? awaddr_q : awaddr;
        wr_data      = w_held ? wdata_q : wdata;
        wr_strb      = w_held ? wstrb_q : wstrb;
        wr_idx       = addr_index(wr_addr);
        wr_ok        = !addr_oob(wr_addr) && !RO_MASK[wr_idx];
        case (w_state)
            W_IDLE: if (commit) w_state_next = W_RESP;
            W_RESP: if (bready) w_state_next = W_IDLE;
            default: w_state_next = W_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            w_state  <= W_IDLE;
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            awaddr_q <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            bresp    <= RESP_OKAY;
            wr_pulse <= '0;
            for (int i = 0; i < W; i++) begin
                register_out[i] <= RST_VAL;
            end
        end else begin
            w_state  <= w_state_next;
            wr_pulse <= '0;
            if (commit) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
                bresp   <= wr_ok ? RESP_OKAY : RESP_SLVERR;
                if (wr_ok) begin
                    register_out[wr_idx] <= merge_bytes(register_out[wr_idx], wr_data,
                                                        wr_strb, W1C_MASK[wr_idx]);
                    wr_pulse[wr_idx]     <= 1'b1;
                end
            end else begin
                if (aw_beat) begin
                    aw_held  <= 1'b1;
                    awaddr_q <= awaddr;
                end
                if (w_beat) begin
                    w_held  <= 1'b1;
                    wdata_q <= wdata;
                    wstrb_q <= wstrb;
                end
            end
        end
    end

    r_state_t           r_state, r_state_next;
    logic               ar_beat, rd_ok;
    logic [CLOG2_W-1:0] rd_idx;

    always_comb begin
        r_state_next = r_state;
        arready      = (r_state == R_IDLE);
        rvalid       = (r_state == R_RESP);
        ar_beat      = arvalid && arready;
        rd_idx       = addr_index(araddr);
        rd_ok        = !addr_oob(araddr);
        case (r_state)
            R_IDLE: if (ar_beat) r_state_next = R_RESP;
            R_RESP: if (rready) r_state_next = R_IDLE;
            default: r_state_next = R_IDLE;
        endcase
    end

    // Reads sample register_out before any same-edge write commit lands.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state  <= R_IDLE;
            rdata    <= '0;
            rresp    <= RESP_OKAY;
            rd_pulse <= '0;
        end else begin
            r_state  <= r_state_next;
            rd_pulse <= '0;
            if (ar_beat) begin
                if (!rd_ok) begin
                    rdata <= '0;
                    rresp <= RESP_SLVERR;
                end else begin
                    rdata            <= RO_MASK[rd_idx] ? register_in[rd_idx] : register_out[rd_idx];
                    rresp            <= RESP_OKAY;
                    rd_pulse[rd_idx] <= 1'b1;
                end
            end
        end
    end

endmodule
